// File: rtl/load_store_unit.sv
// Data-memory stage: byte/half/word load/store over a req/ack handshake with
// lane steering, load extension, misalignment trap and bounded-wait timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic        Sext,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] Rdata,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemAck
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_wr, r_sext, r_err;
    logic [1:0]  r_size, r_off;
    logic [7:0]  r_cnt;
    logic [31:0] r_memaddr, r_wdata, r_rdata;
    logic [3:0]  r_be;

    logic        w_accept, w_misal, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_lane, w_fmt;
    logic [15:0] w_half;

    assign w_accept = (r_state == IDLE) && Req;
    assign w_tmo    = (r_cnt == 8'(TIMEOUT - 1));
    assign w_misal  = (Size == 2'b11) || (Size == 2'b01 && Addr[0]) ||
                      (Size == 2'b10 && Addr[1:0] != 2'b00);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (Size)
            2'b00: begin
                w_be    = 4'b0001 << Addr[1:0];
                w_wdata = {4{Wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {Addr[1], 1'b0};
                w_wdata = {2{Wdata[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = Wdata;
            end
            default: ;
        endcase
    end

    // Lane selection uses the latched offset, not the live address
    assign w_lane = MemRdata >> {r_off, 3'b000};
    assign w_half = r_off[1] ? MemRdata[31:16] : MemRdata[15:0];

    always_comb begin
        case (r_size)
            2'b00:   w_fmt = {{24{r_sext & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_fmt = {{16{r_sext & w_half[15]}}, w_half};
            default: w_fmt = MemRdata;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Req) w_next = w_misal ? RESP : ACCESS;
            ACCESS:  if (MemAck || w_tmo) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_wr      <= 1'b0;
            r_sext    <= 1'b0;
            r_err     <= 1'b0;
            r_size    <= 2'b00;
            r_off     <= 2'b00;
            r_cnt     <= 8'h0;
            r_memaddr <= 32'h0;
            r_wdata   <= 32'h0;
            r_be      <= 4'b0000;
            r_rdata   <= 32'h0;
        end else if (w_accept) begin
            r_wr      <= Wr;
            r_sext    <= Sext;
            r_size    <= Size;
            r_off     <= Addr[1:0];
            r_memaddr <= {Addr[31:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_err     <= w_misal;
            r_cnt     <= 8'h0;
        end else if (r_state == ACCESS) begin
            // An ack on the final allowed cycle still counts as success
            if (MemAck) begin
                r_err <= 1'b0;
                if (!r_wr) r_rdata <= w_fmt;
            end else begin
                r_cnt <= r_cnt + 8'h1;
                if (w_tmo) r_err <= 1'b1;
            end
        end
    end

    assign Busy     = (r_state != IDLE);
    assign Done     = (r_state == RESP);
    assign Err      = (r_state == RESP) && r_err;
    assign MemReq   = (r_state == ACCESS);
    assign MemWe    = (r_state == ACCESS) && r_wr;
    assign MemAddr  = r_memaddr;
    assign MemBe    = r_be;
    assign MemWdata = r_wdata;
    assign Rdata    = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected {Err,Rdata},
// monitor pops and compares on every Done pulse.
module tb_load_store_unit;

    logic        Clk = 1'b0, Clrn = 1'b0;
    logic        Req = 1'b0, Wr = 1'b0, Sext = 1'b0, MemAck = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic [31:0] Addr = 32'h0, Wdata = 32'h0, MemRdata = 32'h0;
    logic        Busy, Done, Err, MemReq, MemWe;
    logic [31:0] Rdata, MemAddr, MemWdata;
    logic [3:0]  MemBe;

    int n_chk = 0, n_fail = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model_rd = 32'h0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Clrn(Clrn), .Req(Req), .Wr(Wr), .Size(Size), .Sext(Sext),
        .Addr(Addr), .Wdata(Wdata), .Busy(Busy), .Done(Done), .Err(Err),
        .Rdata(Rdata), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemBe(MemBe), .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest expected response
    always @(negedge Clk) begin
        if (Done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'(0));
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("err", 32'(Err), 32'(e[32]));
                chk("rdata", Rdata, e[31:0]);
            end
        end else if (Err) begin
            chk("err_without_done", 32'(Err), 32'(0));
        end
    end

    // mode: >=0 ack after that many wait cycles, -1 no ack (timeout), -2 misaligned
    task automatic do_op(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] mrd, input int mode, input logic hold,
                         input logic [3:0] e_be, input logic [31:0] e_wd,
                         input logic [31:0] e_rd);
        int cnt;
        logic ok_load;
        ok_load = !wr && mode >= 0;
        if (ok_load) model_rd = e_rd;
        exp_q.push_back({(mode < 0), model_rd});
        chk("busy_idle", 32'(Busy), 32'(0));
        Req = 1'b1; Wr = wr; Size = sz; Sext = sx; Addr = ad; Wdata = wd;
        @(negedge Clk);
        if (!hold) Req = 1'b0;
        if (mode == -2) begin
            chk("misal_memreq", 32'(MemReq), 32'(0));
            chk("misal_done_c1", 32'(Done), 32'(1));
        end else begin
            chk("memreq_c1", 32'(MemReq), 32'(1));
            chk("memwe", 32'(MemWe), 32'(wr));
            chk("memaddr", MemAddr, {ad[31:2], 2'b00});
            chk("membe", 32'(MemBe), 32'(e_be));
            chk("memwdata", MemWdata, e_wd);
            if (mode == -1) begin
                cnt = 0;
                while (MemReq && cnt < 20) begin
                    cnt++;
                    @(negedge Clk);
                end
                chk("timeout_req_cycles", 32'(cnt), 32'(4));
                chk("timeout_done", 32'(Done), 32'(1));
            end else begin
                for (int w = 0; w < mode; w++) begin
                    chk("memreq_wait", 32'(MemReq), 32'(1));
                    @(negedge Clk);
                end
                MemAck = 1'b1; MemRdata = mrd;
                @(negedge Clk);
                MemAck = 1'b0;
                chk("done_latency", 32'(Done), 32'(1));
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_done", 32'(Done), 32'(0));
        chk("rst_err", 32'(Err), 32'(0));
        chk("rst_rdata", Rdata, 32'h0);
        chk("rst_memreq", 32'(MemReq), 32'(0));
        chk("rst_memwe", 32'(MemWe), 32'(0));
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_membe", 32'(MemBe), 32'(0));
        chk("rst_memwdata", MemWdata, 32'h0);
        Clrn = 1'b1;
        @(negedge Clk);

        // Reset in the middle of an access: MemReq must fall without a clock edge
        Req = 1'b1; Wr = 1'b0; Size = 2'b10; Addr = 32'h5000;
        @(negedge Clk);
        Req = 1'b0;
        chk("abort_memreq_before", 32'(MemReq), 32'(1));
        #2 Clrn = 1'b0;
        #1 chk("abort_memreq_async", 32'(MemReq), 32'(0));
        chk("abort_busy", 32'(Busy), 32'(0));
        MemAck = 1'b1; MemRdata = 32'hCAFEF00D;
        @(negedge Clk);
        Clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("stray_ack_done", 32'(Done), 32'(0));
        end
        MemAck = 1'b0;
        chk("stray_ack_rdata", Rdata, 32'h0);
        @(negedge Clk);

        //    wr    sz     sx    addr          wdata         memrdata      mode hold be       wdata_exp     rdata_exp
        do_op(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hDEADBEEF, 32'h0,        0,  1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
        do_op(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0,        32'h80FF7F01, 3,  1'b0, 4'b1000, 32'h0,        32'hFFFFFF80);
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0,        32'h80FF7F01, 3,  1'b0, 4'b1000, 32'h0,        32'h00000080);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000ABCD, 32'h0,        1,  1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
        do_op(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h7FFF0000, 0,  1'b0, 4'b1100, 32'h0,        32'h00007FFF);
        do_op(1'b0, 2'b01, 1'b1, 32'h0000_4000, 32'h0,        32'h1234F00D, 2,  1'b0, 4'b0011, 32'h0,        32'hFFFFF00D);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_2001, 32'h0,        32'h0,       -2,  1'b0, 4'b0000, 32'h0,        32'h0);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0,        32'h0,       -2,  1'b0, 4'b0000, 32'h0,        32'h0);
        do_op(1'b0, 2'b11, 1'b0, 32'h0000_2000, 32'h0,        32'h0,       -2,  1'b0, 4'b0000, 32'h0,        32'h0);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,        32'h12345678, 1,  1'b0, 4'b1111, 32'h0,        32'h12345678);
        // Timeout with Req held, then the next op issued in the cycle after RESP
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0,        32'h0,       -1,  1'b1, 4'b1111, 32'h0,        32'h0);
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0,        32'h0000A500, 0,  1'b0, 4'b0010, 32'h0,        32'h000000A5);

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        chk("final_rdata", Rdata, 32'h000000A5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the ALU in the single-cycle CPU. It takes the ALU result as the effective address, performs one byte, halfword or word load/store over a req/ack memory handshake, and stalls the core while the access is outstanding. It handles byte-lane steering, load sign/zero extension, misalignment detection and a bounded-wait timeout.

## Interface
- TIMEOUT, 255: number of consecutive ACCESS cycles without MemAck before the access aborts with an error; legal range 1..255.

- Clk  in  1  rising-edge clock
- Clrn  in  1  asynchronous active-low reset
- Req  in  1  core requests a memory op; sampled only in IDLE
- Wr  in  1  1 = store, 0 = load
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Sext  in  1  1 = sign-extend loads, 0 = zero-extend
- Addr  in  32  effective address, the ALU result R
- Wdata  in  32  store data, low-aligned
- Busy  out  1  stall to core; 1 whenever state is not IDLE
- Done  out  1  one-cycle pulse at op completion
- Err  out  1  one-cycle pulse with Done on misalignment or timeout
- Rdata  out  32  formatted load data; held between successful loads
- MemReq  out  1  memory request, held until MemAck
- MemWe  out  1  memory write enable, valid with MemReq
- MemAddr  out  32  word address {Addr[31:2],2'b00}
- MemBe  out  4  byte enables, bit i selects byte lane i (little-endian)
- MemWdata  out  32  lane-replicated store data
- MemRdata  in  32  read data, valid with MemAck
- MemAck  in  1  memory completes the access this cycle

## Operation
- Clrn is asynchronous and active-low, per the codebase.
- States: IDLE, ACCESS, RESP.
- IDLE with Req=1:
  - Latch Wr, Size, Sext, Addr[1:0], MemAddr, MemBe, MemWdata.
  - If misaligned, go to RESP with the error flag set.
  - Otherwise go to ACCESS and clear the wait counter.
- Misaligned: Size=11; half with Addr[0]=1; word with Addr[1:0]≠00.
- ACCESS: MemReq=1, MemWe=latched Wr.
  - On MemAck: a load captures formatted MemRdata into Rdata; go to RESP with error clear.
  - Otherwise the counter increments. When TIMEOUT ACCESS cycles have passed without ack, go to RESP with the error flag set and drop MemReq.
- RESP: Done=1, Err=error flag; return to IDLE.
- Byte enables:
  - byte: 0001<<Addr[1:0]
  - half: 0011<<{Addr[1],1'b0}
  - word: 1111
- MemWdata:
  - byte: {4{Wdata[7:0]}}
  - half: {2{Wdata[15:0]}}
  - word: Wdata
- Load format: select the lane given by the latched Addr[1:0]. Extend 8 or 16 bits to 32 using Sext; word loads are passed through unchanged.
- Rdata changes only on a successful load. Stores, errors and reset-free idle cycles leave it unchanged.
- MemAck outside ACCESS is ignored.
- Req while Busy=1 is ignored. The core holds its instruction while stalled.

## Timing
- Reset values:
  - state IDLE; Busy 0, Done 0, Err 0, Rdata 0
  - MemReq 0, MemWe 0, MemAddr 0, MemBe 0, MemWdata 0
  - counter 0
- Reset mid-ACCESS drops MemReq immediately (asynchronously). A later MemAck is ignored.
- Busy, Done, Err, MemReq and MemWe decode from registered state; none depends combinationally on Req or MemAck.
- Cycle 0 is the IDLE cycle with Req=1.
  - Earliest ACCESS is cycle 1.
  - MemAck in ACCESS cycle k gives Done in cycle k+1.
  - Zero-wait memory (ack in cycle 1) gives Done in cycle 2.
- Misaligned request: Done=Err=1 in cycle 1, and MemReq is never asserted.
- Timeout: MemReq is high for exactly TIMEOUT cycles, then Done=Err=1.
- If MemAck arrives on the TIMEOUT-th cycle, the ack wins and there is no error.
- Back-to-back requests: the next Req is accepted in the cycle after RESP. Minimum spacing is 3 cycles per op.

## Test plan
- Reset: hold Clrn=0 mid-ACCESS → MemReq=0 asynchronously. All outputs read zero, and a subsequent MemAck produces no Done.
- Word store, zero-wait:
  - Stimulus: Req, Wr=1, Size=10, Addr=0x1000, Wdata=0xDEADBEEF.
  - Cycle 1: MemReq=1, MemBe=1111, MemAddr=0x1000, MemWdata=0xDEADBEEF.
  - Ack in cycle 1 → Done=1 in cycle 2, Err=0, Rdata unchanged.
- Byte load with sign extension:
  - Stimulus: Addr=0x2003, Size=00, Sext=1, MemRdata=0x80FF7F01, ack after 3 wait cycles.
  - Expect MemBe=1000 and Rdata=0xFFFFFF80.
  - Repeat with Sext=0 → Rdata=0x00000080.
- Half store at Addr=0x2002, Wdata=0x0000ABCD → MemBe=1100, MemWdata=0xABCDABCD.
  - Half load at 0x2002 with MemRdata=0x7FFF0000, Sext=1 → Rdata=0x00007FFF.
- Misalignment: word at 0x2001, half at 0x2001, and Size=11 → each gives Done=Err=1 in cycle 1, MemReq never high, Rdata unchanged.
- Timeout with TIMEOUT=4:
  - No ack → MemReq high exactly 4 cycles, then Done=Err=1.
  - Ack on the 4th ACCESS cycle → Done=1, Err=0.
  - Req held high throughout → the next op starts in the cycle after RESP.
